// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bundle for regfile_access_arbiter.
//   master : requester (drives req/we/addr_a/addr_b/wdata, sees gnt/rvalid/rdata_*)
//   slave  : arbiter   (opposite directions)
// gnt is combinational; a transfer happens in any cycle with req & gnt.
// rvalid is a one-cycle pulse and rdata_* hold until the next read return.
interface regfile_access_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  modport master (
    output req, we, addr_a, addr_b, wdata,
    input  gnt, rvalid, rdata_a, rdata_b
  );

  modport slave (
    input  req, we, addr_a, addr_b, wdata,
    output gnt, rvalid, rdata_a, rdata_b
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing a 1W/2R register file between r0 (core) and
// r1 (debug/loader). One operation per cycle, all rf_* lines registered.
//   clk, rst_n        : clock, async active-low reset
//   r0, r1            : requester ports (regfile_access_arbiter_if.slave)
//   rf_a1/a2/a3       : read/read/write addresses, unused high bits forced 0
//   rf_wdata, rf_we   : write data / write enable (one-cycle pulse)
//   rf_re             : read enable (one-cycle pulse)
//   rf_rd1, rf_rd2    : read data, captured at the end of the rf_re cycle
//   init_done         : arbiter is accepting requests
// Optional feature, macro RF_INIT_CLEAR_EN: after reset the register file is
// cleared (one write per cycle) before any grant is given.
// Timing: grant in T -> rf strobe in T+1 -> rvalid to the issuer in T+2.
module regfile_access_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_access_arbiter_if.slave r0,
  regfile_access_arbiter_if.slave r1,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              init_done
);
  localparam int NUM_REQ = 2;
  localparam int IW      = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((64'd1 << IW) - 64'd1);

  // requester fields gathered into packed arrays, indexed by requester id
  logic [NUM_REQ-1:0]             req, we, gnt;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a, addr_b;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata;

  assign req    = {r1.req,    r0.req};
  assign we     = {r1.we,     r0.we};
  assign addr_a = {r1.addr_a, r0.addr_a};
  assign addr_b = {r1.addr_b, r0.addr_b};
  assign wdata  = {r1.wdata,  r0.wdata};

  logic              init_done_q, init_done_d;
  logic              rr_q, rr_d;          // 1: r1 wins the next contest
  logic              rf_we_q, rf_we_d;
  logic              rf_re_q, rf_re_d;
  logic [ADDR_W-1:0] rf_a1_q, rf_a1_d;
  logic [ADDR_W-1:0] rf_a2_q, rf_a2_d;
  logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              rd_own_q, rd_own_d;  // issuer of the read now on the rf
  logic [NUM_REQ-1:0]             rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              sel;

`ifdef RF_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     init_cnt_q, init_cnt_d;
`endif

  always_comb begin
    init_done_d = init_done_q;
    rr_d        = rr_q;
    rf_we_d     = 1'b0;
    rf_re_d     = 1'b0;
    rf_a1_d     = rf_a1_q;
    rf_a2_d     = rf_a2_q;
    rf_a3_d     = rf_a3_q;
    rf_wdata_d  = rf_wdata_q;
    rd_own_d    = rd_own_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    rvalid_d    = '0;

    // grants are gated by init_done, so nothing is granted before RUN
    gnt[0] = init_done_q & req[0] & (~req[1] | ~rr_q);
    gnt[1] = init_done_q & req[1] & (~req[0] |  rr_q);
    sel    = gnt[1];

    if (|gnt) begin
      rr_d = gnt[0];
      if (we[sel]) begin
        rf_we_d    = 1'b1;
        rf_a3_d    = addr_a[sel] & AMASK;
        rf_wdata_d = wdata[sel];
      end else begin
        rf_re_d  = 1'b1;
        rf_a1_d  = addr_a[sel] & AMASK;
        rf_a2_d  = addr_b[sel] & AMASK;
        rd_own_d = sel;
      end
    end

`ifdef RF_INIT_CLEAR_EN
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      rf_we_d    = 1'b1;
      rf_a3_d    = ADDR_W'(init_cnt_q);
      rf_wdata_d = '0;
      init_cnt_d = init_cnt_q + 1'b1;
      // init_done rises together with the last clearing write
      if (init_cnt_q == IW'(NUM_REGS - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
`else
    init_done_d = 1'b1;
`endif

    // read return: rf data is only meaningful during the rf_re cycle
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rf_re_q && (rd_own_q == 1'(i))) begin
        rvalid_d[i]  = 1'b1;
        rdata_a_d[i] = rf_rd1;
        rdata_b_d[i] = rf_rd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
      rr_q        <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_re_q     <= 1'b0;
      rf_a1_q     <= '0;
      rf_a2_q     <= '0;
      rf_a3_q     <= '0;
      rf_wdata_q  <= '0;
      rd_own_q    <= 1'b0;
      rvalid_q    <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
`ifdef RF_INIT_CLEAR_EN
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
`endif
    end else begin
      init_done_q <= init_done_d;
      rr_q        <= rr_d;
      rf_we_q     <= rf_we_d;
      rf_re_q     <= rf_re_d;
      rf_a1_q     <= rf_a1_d;
      rf_a2_q     <= rf_a2_d;
      rf_a3_q     <= rf_a3_d;
      rf_wdata_q  <= rf_wdata_d;
      rd_own_q    <= rd_own_d;
      rvalid_q    <= rvalid_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
`ifdef RF_INIT_CLEAR_EN
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  assign r0.gnt     = gnt[0];
  assign r1.gnt     = gnt[1];
  assign r0.rvalid  = rvalid_q[0];
  assign r1.rvalid  = rvalid_q[1];
  assign r0.rdata_a = rdata_a_q[0];
  assign r1.rdata_a = rdata_a_q[1];
  assign r0.rdata_b = rdata_b_q[0];
  assign r1.rdata_b = rdata_b_q[1];

  assign rf_a1     = rf_a1_q;
  assign rf_a2     = rf_a2_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_re     = rf_re_q;
  assign init_done = init_done_q;
endmodule
